// File: rtl/calc_pkg.sv
// calc_pkg: shared calculator types and widths.
package calc_pkg;
  localparam int CALC_WIDTH = 10;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} ser_state_t;
endpackage

// File: rtl/serial_fa_bit.sv
// serial_fa_bit: combinational 1-bit full adder slice.
module serial_fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequences LSB-first add/sub of two operands through one full-adder slice.
module serial_add_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  ser_state_t state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0] cnt;
  logic carry, sub_l, sum, cout, last, load;
  serial_fa_bit u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .sum (sum),
    .cout(cout)
  );
  assign last = cnt == CW'(WIDTH - 1);
  assign load = state == IDLE && start;
  always_comb begin
    state_nxt = state == IDLE  ? (start ? SHIFT : IDLE) :
                state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    busy      = state != IDLE;
    done      = state == DONE;
  end
  always_ff @(posedge clk_in) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end
  // ovf is captured on the final shift so it is already valid while done is high
  always_ff @(posedge clk_in) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sub_l  <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
    end else if (load) begin
      a_sr   <= op_a;
      b_sr   <= sub ? ~op_b : op_b;
      cnt    <= '0;
      carry  <= sub;
      sub_l  <= sub;
      result <= '0;
      ovf    <= 1'b0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      cnt    <= cnt + 1'b1;
      carry  <= cout;
      result <= {sum, result[WIDTH-1:1]};
      ovf    <= last ? cout ^ sub_l : ovf;
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized self-checking bench against an arithmetic reference model.
module tb_serial_add_ctrl;
  localparam int W = 10;
  localparam int MASK = (1 << W) - 1;
  logic clk_in = 1'b0;
  logic rst, start, sub, busy, done, ovf;
  logic [W-1:0] op_a, op_b, result;
  int tests = 0;
  int errors = 0;
  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .op_a  (op_a),
    .op_b  (op_b),
    .busy  (busy),
    .done  (done),
    .result(result),
    .ovf   (ovf)
  );
  always #5 clk_in = ~clk_in;
  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask
  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  // Reference: plain modular arithmetic; ovf is carry-out for add, borrow for sub.
  task automatic run_op(input int a, input int b, input bit s, input bit spam);
    int n, busy_n, exp_r;
    bit exp_o;
    exp_r = s ? (a - b) & MASK : (a + b) & MASK;
    exp_o = s ? (a < b) : ((a + b) > MASK);
    op_a = W'(a);
    op_b = W'(b);
    sub = s;
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 1;
    busy_n = 0;
    while (!done && n < 3 * W) begin
      busy_n += int'(busy);
      op_a = W'($urandom);
      op_b = W'($urandom);
      sub = 1'($urandom);
      start = spam && (n == 3 || n == 10);
      tick;
      n++;
    end
    start = 1'b0;
    busy_n += int'(busy);
    check("latency", n, W + 1);
    check("busy_cycles", busy_n, W + 1);
    check("result", int'(result), exp_r);
    check("ovf", int'(ovf), int'(exp_o));
    tick;
    check("done_single", int'(done), 0);
    check("busy_after", int'(busy), 0);
    check("result_held", int'(result), exp_r);
    check("ovf_held", int'(ovf), int'(exp_o));
  endtask
  initial begin
    int n, d1, gap, dn;
    rst = 1'b1;
    start = 1'b0;
    sub = 1'b0;
    op_a = '0;
    op_b = '0;
    tick;
    tick;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_ovf", int'(ovf), 0);
    rst = 1'b0;
    tick;
    run_op(3, 4, 0, 0);
    run_op(1023, 1, 0, 0);
    run_op(512, 511, 0, 0);
    run_op(5, 7, 1, 0);
    run_op(7, 5, 1, 0);
    run_op(0, 0, 1, 0);
    run_op(123, 456, 0, 1);
    // abort mid-shift; start asserted alongside rst must lose
    op_a = W'(1023);
    op_b = W'(1023);
    sub = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    start = 1'b1;
    tick;
    rst = 1'b0;
    start = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_result", int'(result), 0);
    check("abort_ovf", int'(ovf), 0);
    check("abort_done", int'(done), 0);
    dn = 0;
    repeat (W + 3) begin
      dn += int'(done);
      tick;
    end
    check("abort_no_done", dn, 0);
    run_op(100, 200, 0, 0);
    // back-to-back with start held high
    op_a = W'(10);
    op_b = W'(20);
    sub = 1'b0;
    start = 1'b1;
    tick;
    op_a = W'(30);
    op_b = W'(40);
    n = 1;
    while (!done && n < 3 * W) begin
      tick;
      n++;
    end
    d1 = n;
    check("b2b_first", int'(result), 30);
    tick;
    check("b2b_idle_busy", int'(busy), 0);
    tick;
    start = 1'b0;
    n = 0;
    while (!done && n < 3 * W) begin
      tick;
      n++;
    end
    gap = n + 2;
    check("b2b_first_latency", d1, W + 1);
    check("b2b_gap", gap, W + 2);
    check("b2b_second", int'(result), 70);
    tick;
    check("b2b_done_single", int'(done), 0);
    for (int i = 0; i < 20; i++)
      run_op(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)), 1'($urandom), 1'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Sequencer for the calculator's bit-serial adder. It latches two operands on a start strobe and clocks them LSB-first through a single-bit full-adder slice for exactly WIDTH cycles. It accumulates the sum in a shift register and reports completion with a done pulse. It sits between the calculator's operand/state logic and the arithmetic slice, and replaces the parallel `answ + num` add with a sequenced serial operation. It also supports subtraction by B-inversion and carry-in.

## Interface
- WIDTH, 10, operand/result width in bits (≥ 2)
- clk_in  input  1  system clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- start  input  1  request operation; sampled only in IDLE
- sub  input  1  0 = A+B, 1 = A−B; latched with operands
- op_a  input  WIDTH  operand A, unsigned; latched on accepted start
- op_b  input  WIDTH  operand B, unsigned; latched on accepted start
- busy  output  1  high while in SHIFT or DONE
- done  output  1  single-cycle pulse, result valid
- result  output  WIDTH  sum/difference mod 2^WIDTH; held until next accepted start
- ovf  output  1  add: final carry-out; sub: borrow (inverted final carry); held with result

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1, load the A and B shift registers. B is loaded as ~op_b when sub=1.
  - Load the carry flop with the value of sub.
  - Clear the bit counter and the result shift register, clear ovf, and go to SHIFT.
- SHIFT, each cycle:
  - The slice computes sum = a0 ^ b0 ^ c and cout = majority(a0, b0, c) on the current LSBs.
  - The carry flop takes cout.
  - A and B shift right by one.
  - result shifts right with the sum bit inserted at the MSB.
  - The counter increments.
  - After the cycle in which the counter equals WIDTH−1, go to DONE.
- DONE:
  - done=1 for this one cycle.
  - ovf = carry flop XOR sub_latched.
  - Next state is IDLE unconditionally.
- start is ignored in SHIFT and DONE; it is not queued.
- Arithmetic is unsigned modulo 2^WIDTH; no saturation.
- Reset:
  - state=IDLE, busy=0, done=0, result=0, ovf=0.
  - Internal registers and counter are cleared.
  - Reset during SHIFT aborts the operation, with no done pulse.
  - rst takes priority over start in the same cycle.

## Timing
- Start sampled at edge T0 → SHIFT occupies cycles T0+1 … T0+WIDTH.
- done=1 and result/ovf valid at cycle T0+WIDTH+1.
- busy rises the cycle after the accepted start and falls with the exit from DONE.
- Earliest next accepted start is at edge T0+WIDTH+2, i.e. the first IDLE cycle. This gives a throughput of one operation per WIDTH+2 cycles.
- result is not a valid answer during SHIFT; it shows partial shifting and must only be consumed on done or while idle after done.
- op_a, op_b and sub may change freely after the accepted start edge.
- Counter width is $clog2(WIDTH). The counter never wraps within an operation.

## Structure
- Shared package calc_pkg holds:
  - the ser_state_t enum {IDLE, SHIFT, DONE};
  - the CALC_WIDTH constant (10), used as the WIDTH default by calculator-level instances.
- One sub-module, serial_fa_bit: a combinational 1-bit full adder (a, b, cin → sum, cout). The carry flop stays in serial_add_ctrl so that reset and load are controlled in one place.
- Estimated size: roughly 150–200 lines of RTL.

## Test plan
- WIDTH=10, start with op_a=3, op_b=4, sub=0 → done pulses exactly 11 cycles after the start edge; result=7, ovf=0; busy is high for 11 cycles.
- op_a=1023, op_b=1, add → result=0, ovf=1. Also op_a=512, op_b=511 → result=1023, ovf=0.
- op_a=5, op_b=7, sub=1 → result=1022, ovf=1 (borrow). Also op_a=7, op_b=5 → result=2, ovf=0.
- Pulse start again at cycles 3 and 10 of an operation, with different operands → both ignored. The first result is unchanged and a single done pulse occurs.
- Assert rst at cycle 5 of SHIFT → next cycle busy=0, result=0, ovf=0, and no done pulse. A fresh start of 100+200 then yields 300.
- Back-to-back: start held high continuously with 10+20 then 30+40 presented → accepted starts are WIDTH+2 cycles apart; results are 30 then 70, each with a one-cycle done.
